// File: rtl/udp_header_splitter.sv
// udp_header_splitter: splits a 64-bit UDP datagram stream into a single-beat
// header stream (tagged with the destination port) and a payload stream that
// is trimmed to the UDP length. Malformed datagrams are dropped and counted.
module udp_header_splitter #(
    parameter int TRUNCATE_EN = 1,
    parameter int CNT_WIDTH   = 16
) (
    input  logic                 aclk,
    input  logic                 rst,
    input  logic [63:0]          s_udp_tdata,
    input  logic [7:0]           s_udp_tkeep,
    input  logic                 s_udp_tlast,
    input  logic                 s_udp_tvalid,
    output logic                 s_udp_tready,
    output logic [63:0]          m_udphdr_tdata,
    output logic [15:0]          m_udphdr_tdest,
    output logic                 m_udphdr_tvalid,
    input  logic                 m_udphdr_tready,
    output logic [63:0]          m_udpdata_tdata,
    output logic [7:0]           m_udpdata_tkeep,
    output logic                 m_udpdata_tlast,
    output logic                 m_udpdata_tvalid,
    input  logic                 m_udpdata_tready,
    output logic [CNT_WIDTH-1:0] good_count,
    output logic [CNT_WIDTH-1:0] drop_count,
    output logic                 short_pkt
);

    localparam logic [1:0] ST_HDR     = 2'd0;
    localparam logic [1:0] ST_PAY     = 2'd1;
    localparam logic [1:0] ST_EMPTY   = 2'd2;
    localparam logic [1:0] ST_DISCARD = 2'd3;

    logic [1:0]  state;
    logic [15:0] rem_bytes;   // payload bytes still owed to the current datagram
    logic        frame_open;  // header beat of the current datagram had no tlast

    logic [15:0] udp_len;
    logic [3:0]  beat_bytes;
    logic        pslot_free;
    logic        hslot_free;
    logic        in_fire;
    logic        hdr_bad;
    logic        trim_hit;
    logic [8:0]  trim_mask;

    // UDP length is big-endian in header bytes 4..5
    assign udp_len    = {s_udp_tdata[39:32], s_udp_tdata[47:40]};
    assign beat_bytes = 4'($countones(s_udp_tkeep));
    assign pslot_free = !m_udpdata_tvalid || m_udpdata_tready;
    assign hslot_free = !m_udphdr_tvalid || m_udphdr_tready;
    assign in_fire    = s_udp_tvalid && s_udp_tready;
    assign hdr_bad    = (s_udp_tkeep != 8'hFF) || (udp_len < 16'd8);
    // When the trim fires, rem_bytes is 1..8, so its low nibble is enough
    assign trim_hit   = (TRUNCATE_EN != 0) && (rem_bytes <= {12'd0, beat_bytes});
    assign trim_mask  = (9'd1 << rem_bytes[3:0]) - 9'd1;

    // Input ready depends on which output the current state feeds
    always_comb begin
        // NOTE: default assignment first so no path leaves the output unassigned (no latch).
        s_udp_tready = 1'b0;
        case (state)
            ST_HDR:     s_udp_tready = hslot_free;
            ST_PAY:     s_udp_tready = pslot_free;
            ST_EMPTY:   s_udp_tready = 1'b0;
            ST_DISCARD: s_udp_tready = 1'b1;
            default:    s_udp_tready = 1'b0;
        endcase
    end

    // Parser FSM, output registers and statistics
    always_ff @(posedge aclk) begin
        if (rst) begin
            // NOTE: only control state is reset; data registers are qualified by tvalid.
            state            <= ST_HDR;
            rem_bytes        <= 16'd0;
            frame_open       <= 1'b0;
            m_udphdr_tvalid  <= 1'b0;
            m_udpdata_tvalid <= 1'b0;
            good_count       <= '0;
            drop_count       <= '0;
            short_pkt        <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments; later statements in this block override earlier ones.
            short_pkt <= 1'b0;
            if (m_udphdr_tready)  m_udphdr_tvalid  <= 1'b0;
            if (m_udpdata_tready) m_udpdata_tvalid <= 1'b0;

            case (state)
                ST_HDR: begin
                    if (in_fire) begin
                        if (hdr_bad) begin
                            drop_count <= drop_count + CNT_WIDTH'(1);
                            state      <= s_udp_tlast ? ST_HDR : ST_DISCARD;
                        end else begin
                            m_udphdr_tdata  <= s_udp_tdata;
                            m_udphdr_tdest  <= {s_udp_tdata[23:16], s_udp_tdata[31:24]};
                            m_udphdr_tvalid <= 1'b1;
                            good_count      <= good_count + CNT_WIDTH'(1);
                            rem_bytes       <= udp_len - 16'd8;
                            frame_open      <= !s_udp_tlast;
                            if (s_udp_tlast || ((TRUNCATE_EN != 0) && (udp_len == 16'd8))) begin
                                state     <= ST_EMPTY;
                                short_pkt <= s_udp_tlast && (udp_len > 16'd8);
                            end else begin
                                state <= ST_PAY;
                            end
                        end
                    end
                end

                ST_PAY: begin
                    if (in_fire) begin
                        m_udpdata_tdata  <= s_udp_tdata;
                        m_udpdata_tvalid <= 1'b1;
                        if (trim_hit) begin
                            m_udpdata_tkeep <= trim_mask[7:0];
                            m_udpdata_tlast <= 1'b1;
                            state           <= s_udp_tlast ? ST_HDR : ST_DISCARD;
                        end else begin
                            m_udpdata_tkeep <= s_udp_tkeep;
                            m_udpdata_tlast <= s_udp_tlast;
                            rem_bytes       <= rem_bytes - {12'd0, beat_bytes};
                            if (s_udp_tlast) begin
                                // Without truncation the length is not tracked, so no short report
                                short_pkt <= (TRUNCATE_EN != 0);
                                state     <= ST_HDR;
                            end
                        end
                    end
                end

                ST_EMPTY: begin
                    if (pslot_free) begin
                        m_udpdata_tdata  <= 64'd0;
                        m_udpdata_tkeep  <= 8'd0;
                        m_udpdata_tlast  <= 1'b1;
                        m_udpdata_tvalid <= 1'b1;
                        state            <= frame_open ? ST_DISCARD : ST_HDR;
                    end
                end

                ST_DISCARD: begin
                    if (in_fire && s_udp_tlast) state <= ST_HDR;
                end

                default: state <= ST_HDR;
            endcase
        end
    end

endmodule

// File: tb/tb_udp_header_splitter.sv
// Self-checking bench for udp_header_splitter: directed datagrams, a mid-payload
// reset and a randomised run with backpressure, checked against a scoreboard.
module tb_udp_header_splitter;

    typedef struct packed {
        logic [63:0] data;
        logic [7:0]  keep;
        logic        last;
    } beat_t;

    typedef struct packed {
        logic [63:0] data;
        logic [15:0] dest;
    } hdr_t;

    logic        aclk;
    logic        rst;
    logic [63:0] s_udp_tdata;
    logic [7:0]  s_udp_tkeep;
    logic        s_udp_tlast;
    logic        s_udp_tvalid;
    logic        s_udp_tready;
    logic [63:0] m_udphdr_tdata;
    logic [15:0] m_udphdr_tdest;
    logic        m_udphdr_tvalid;
    logic        m_udphdr_tready;
    logic [63:0] m_udpdata_tdata;
    logic [7:0]  m_udpdata_tkeep;
    logic        m_udpdata_tlast;
    logic        m_udpdata_tvalid;
    logic        m_udpdata_tready;
    logic [15:0] good_count;
    logic [15:0] drop_count;
    logic        short_pkt;

    int    n_checks = 0;
    int    n_pass   = 0;
    int    n_fail   = 0;
    int    exp_good = 0;
    int    exp_drop = 0;
    int    exp_short = 0;
    int    short_seen = 0;
    bit    bp_en = 1'b0;

    hdr_t  hdr_q[$];
    beat_t pay_q[$];
    beat_t dg[$];

    udp_header_splitter #(.TRUNCATE_EN(1), .CNT_WIDTH(16)) dut (
        .aclk             (aclk),
        .rst              (rst),
        .s_udp_tdata      (s_udp_tdata),
        .s_udp_tkeep      (s_udp_tkeep),
        .s_udp_tlast      (s_udp_tlast),
        .s_udp_tvalid     (s_udp_tvalid),
        .s_udp_tready     (s_udp_tready),
        .m_udphdr_tdata   (m_udphdr_tdata),
        .m_udphdr_tdest   (m_udphdr_tdest),
        .m_udphdr_tvalid  (m_udphdr_tvalid),
        .m_udphdr_tready  (m_udphdr_tready),
        .m_udpdata_tdata  (m_udpdata_tdata),
        .m_udpdata_tkeep  (m_udpdata_tkeep),
        .m_udpdata_tlast  (m_udpdata_tlast),
        .m_udpdata_tvalid (m_udpdata_tvalid),
        .m_udpdata_tready (m_udpdata_tready),
        .good_count       (good_count),
        .drop_count       (drop_count),
        .short_pkt        (short_pkt)
    );

    initial begin
        aclk = 1'b0;
        forever #5 aclk = ~aclk;
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Header sink: random ready, compare each accepted header with the scoreboard
    initial begin : hdr_sink
        logic rdy;
        hdr_t h;
        m_udphdr_tready = 1'b1;
        forever begin
            @(negedge aclk);
            rdy = bp_en ? ($urandom_range(0, 3) != 0) : 1'b1;
            m_udphdr_tready = rdy;
            if (rst === 1'b0 && m_udphdr_tvalid === 1'b1 && rdy) begin
                if (hdr_q.size() == 0) begin
                    check("hdr_unexpected", {63'd0, m_udphdr_tvalid}, 64'd0);
                end else begin
                    h = hdr_q.pop_front();
                    check("hdr_tdata", m_udphdr_tdata, h.data);
                    check("hdr_tdest", {48'd0, m_udphdr_tdest}, {48'd0, h.dest});
                end
            end
        end
    end

    // Payload sink: random ready, compare each accepted payload beat
    initial begin : pay_sink
        logic rdy;
        beat_t b;
        m_udpdata_tready = 1'b1;
        forever begin
            @(negedge aclk);
            rdy = bp_en ? ($urandom_range(0, 3) != 0) : 1'b1;
            m_udpdata_tready = rdy;
            if (rst === 1'b0 && m_udpdata_tvalid === 1'b1 && rdy) begin
                if (pay_q.size() == 0) begin
                    check("pay_unexpected", {63'd0, m_udpdata_tvalid}, 64'd0);
                end else begin
                    b = pay_q.pop_front();
                    check("pay_tdata", m_udpdata_tdata, b.data);
                    check("pay_tkeep", {56'd0, m_udpdata_tkeep}, {56'd0, b.keep});
                    check("pay_tlast", {63'd0, m_udpdata_tlast}, {63'd0, b.last});
                end
            end
        end
    end

    // Count short_pkt pulses (one per asserted cycle)
    initial begin : short_mon
        forever begin
            @(negedge aclk);
            if (rst === 1'b0 && short_pkt === 1'b1) short_seen++;
        end
    end

    // Build a datagram: header beat plus n_pay payload bytes packed 8 per beat
    task automatic build_dgram(input logic [15:0] port, input int len, input int n_pay,
                               input logic [7:0] hkeep);
        beat_t b;
        int    rem;
        int    n;
        logic [15:0] l16;
        dg.delete();
        l16 = 16'(len);
        b.data = {$urandom, $urandom};
        b.data[23:16] = port[15:8];
        b.data[31:24] = port[7:0];
        b.data[39:32] = l16[15:8];
        b.data[47:40] = l16[7:0];
        b.keep = hkeep;
        b.last = (n_pay == 0);
        dg.push_back(b);
        rem = n_pay;
        while (rem > 0) begin
            n = (rem > 8) ? 8 : rem;
            b.data = {$urandom, $urandom};
            b.keep = 8'((9'd1 << n) - 9'd1);
            b.last = (rem <= 8);
            dg.push_back(b);
            rem -= n;
        end
    endtask

    // Datagram-level reference: what the splitter must emit for dg
    task automatic model_dgram();
        beat_t h;
        beat_t b;
        hdr_t  eh;
        int    len;
        int    r;
        int    n;
        h = dg[0];
        len = int'({h.data[39:32], h.data[47:40]});
        if (h.keep != 8'hFF || len < 8) begin
            exp_drop++;
            return;
        end
        exp_good++;
        eh.data = h.data;
        eh.dest = {h.data[23:16], h.data[31:24]};
        hdr_q.push_back(eh);
        r = len - 8;
        if (h.last || len == 8) begin
            pay_q.push_back('{64'd0, 8'd0, 1'b1});
            if (len > 8 && h.last) exp_short++;
            return;
        end
        for (int i = 1; i < dg.size(); i++) begin
            n = $countones(dg[i].keep);
            b.data = dg[i].data;
            if (r <= n) begin
                b.keep = 8'((9'd1 << r) - 9'd1);
                b.last = 1'b1;
                pay_q.push_back(b);
                return;
            end
            b.keep = dg[i].keep;
            b.last = dg[i].last;
            pay_q.push_back(b);
            r -= n;
            if (dg[i].last) begin
                exp_short++;
                return;
            end
        end
    endtask

    // Present one beat (called at a falling edge) and hold it until accepted
    task automatic send_beat(input beat_t b);
        int n = 0;
        s_udp_tdata  = b.data;
        s_udp_tkeep  = b.keep;
        s_udp_tlast  = b.last;
        s_udp_tvalid = 1'b1;
        #1;
        while (s_udp_tready !== 1'b1 && n < 1000) begin
            @(negedge aclk);
            #1;
            n++;
        end
        if (n >= 1000) check("s_tready_timeout", {63'd0, s_udp_tready}, 64'd1);
        @(negedge aclk);
        s_udp_tvalid = 1'b0;
    endtask

    task automatic send_dgram();
        for (int i = 0; i < dg.size(); i++) begin
            if (bp_en && $urandom_range(0, 3) == 0) @(negedge aclk);
            send_beat(dg[i]);
        end
    endtask

    task automatic run_dgram(input logic [15:0] port, input int len, input int n_pay,
                             input logic [7:0] hkeep);
        build_dgram(port, len, n_pay, hkeep);
        model_dgram();
        send_dgram();
    endtask

    // Wait (bounded) for the scoreboard to empty, then compare statistics
    task automatic drain_and_check(input string tag);
        int n = 0;
        while ((hdr_q.size() != 0 || pay_q.size() != 0) && n < 4000) begin
            @(negedge aclk);
            n++;
        end
        repeat (3) @(negedge aclk);
        check({tag, "_hdr_pending"}, 64'(hdr_q.size()), 64'd0);
        check({tag, "_pay_pending"}, 64'(pay_q.size()), 64'd0);
        check({tag, "_good_count"}, {48'd0, good_count}, 64'(exp_good));
        check({tag, "_drop_count"}, {48'd0, drop_count}, 64'(exp_drop));
        check({tag, "_short_pulses"}, 64'(short_seen), 64'(exp_short));
    endtask

    initial begin : main
        beat_t b;
        hdr_t  eh;
        rst          = 1'b1;
        s_udp_tvalid = 1'b0;
        s_udp_tdata  = 64'd0;
        s_udp_tkeep  = 8'd0;
        s_udp_tlast  = 1'b0;
        repeat (3) @(posedge aclk);
        @(negedge aclk);
        check("rst_hdr_tvalid", {63'd0, m_udphdr_tvalid}, 64'd0);
        check("rst_pay_tvalid", {63'd0, m_udpdata_tvalid}, 64'd0);
        check("rst_good_count", {48'd0, good_count}, 64'd0);
        check("rst_drop_count", {48'd0, drop_count}, 64'd0);
        check("rst_short_pkt", {63'd0, short_pkt}, 64'd0);
        check("rst_s_tready", {63'd0, s_udp_tready}, 64'd1);
        rst = 1'b0;
        @(negedge aclk);

        // Port 0x1234, L = 20, only 4 payload bytes present
        run_dgram(16'h1234, 20, 4, 8'hFF);
        drain_and_check("valid_l20");
        // Header only, L = 8: empty payload frame, no short report
        run_dgram(16'h0050, 8, 0, 8'hFF);
        drain_and_check("hdr_only_l8");
        // L = 12 with 16 payload bytes: trimmed to 4, third beat swallowed
        run_dgram(16'h0035, 12, 16, 8'hFF);
        drain_and_check("trim_l12");
        // L = 40 but input ends after 16 bytes: short datagram
        run_dgram(16'hABCD, 40, 8, 8'hFF);
        drain_and_check("short_l40");
        // L = 4 over 3 beats is dropped, following datagram is forwarded intact
        run_dgram(16'h0101, 4, 20, 8'hFF);
        run_dgram(16'h0202, 21, 13, 8'hFF);
        drain_and_check("drop_then_valid");
        // L = 8 with trailing beats: empty payload, rest discarded
        run_dgram(16'h0303, 8, 10, 8'hFF);
        // Exact fit: length ends on the input tlast
        run_dgram(16'h0404, 16, 8, 8'hFF);
        // Partial header keep: single-beat drop
        run_dgram(16'h0505, 8, 0, 8'h7F);
        drain_and_check("edges");

        // Randomised datagrams under backpressure on both masters
        bp_en = 1'b1;
        for (int i = 0; i < 1000; i++) begin
            int p;
            int sel;
            int len;
            logic [7:0] hk;
            p   = $urandom_range(0, 30);
            sel = $urandom_range(0, 9);
            hk  = 8'hFF;
            len = 8 + p;
            if (sel == 5 || sel == 6) len = 8 + p + $urandom_range(1, 20);
            else if (sel == 7) len = 8 + $urandom_range(0, p);
            else if (sel == 8) len = $urandom_range(0, 7);
            else if (sel == 9) hk = 8'h3F;
            run_dgram(16'($urandom), len, p, hk);
        end
        drain_and_check("random");

        // Reset in the middle of a payload, then a clean datagram
        bp_en = 1'b0;
        @(negedge aclk);
        build_dgram(16'hBEEF, 200, 40, 8'hFF);
        eh.data = dg[0].data;
        eh.dest = 16'hBEEF;
        hdr_q.push_back(eh);
        b = dg[1];
        pay_q.push_back(b);
        exp_good++;
        send_beat(dg[0]);
        send_beat(dg[1]);
        drain_and_check("pre_reset");
        rst = 1'b1;
        @(posedge aclk);
        @(negedge aclk);
        hdr_q.delete();
        pay_q.delete();
        exp_good   = 0;
        exp_drop   = 0;
        exp_short  = 0;
        short_seen = 0;
        check("midrst_good_count", {48'd0, good_count}, 64'd0);
        check("midrst_pay_tvalid", {63'd0, m_udpdata_tvalid}, 64'd0);
        rst = 1'b0;
        @(negedge aclk);
        run_dgram(16'h4321, 30, 22, 8'hFF);
        drain_and_check("post_reset");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
